// File: rtl/mem_stage.sv
// Memory-access stage: drives the req/ack data bus for loads and stores,
// stalls the pipeline while an access is outstanding, and writes load results back.
`ifndef RADDR_WIDTH
`define RADDR_WIDTH 5
`endif
`ifndef RDATA_WIDTH
`define RDATA_WIDTH 32
`endif

module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [`RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                    reg_we_i,
  input  logic [`RDATA_WIDTH-1:0] reg_wdata_i,
  input  logic [3:0]              mem_op_i,
  input  logic [31:0]             mem_addr_i,
  input  logic [31:0]             mem_sdata_i,
  output logic [`RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                    reg_we_o,
  output logic [`RDATA_WIDTH-1:0] reg_wdata_o,
  output logic                    dbus_req_o,
  output logic                    dbus_we_o,
  output logic [31:0]             dbus_addr_o,
  output logic [3:0]              dbus_be_o,
  output logic [31:0]             dbus_wdata_o,
  input  logic [31:0]             dbus_rdata_i,
  input  logic                    dbus_ack_i,
  output logic                    stallreq_o,
  output logic                    misalign_o,
  output logic                    bus_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
                         OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [31:0]          rdata_q;
  logic                 timeout_q;
  logic                 bus_err_q;

  logic        is_load, is_store, misalign, mem_go, timeout_hit;
  logic [3:0]  be_n;
  logic [31:0] wdata_n, byte_sh, half_sh, load_val;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    misalign = 1'b0;
    case (mem_op_i)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin is_load = 1'b1; misalign = mem_addr_i[0]; end
      OP_LW:         begin is_load = 1'b1; misalign = |mem_addr_i[1:0]; end
      OP_SB:         is_store = 1'b1;
      OP_SH:         begin is_store = 1'b1; misalign = mem_addr_i[0]; end
      OP_SW:         begin is_store = 1'b1; misalign = |mem_addr_i[1:0]; end
      default:       ;
    endcase
  end

  assign mem_go      = (is_load | is_store) & ~misalign;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    case (mem_op_i)
      OP_LB, OP_LBU, OP_SB: begin
        be_n    = 4'b0001 << mem_addr_i[1:0];
        wdata_n = {4{mem_sdata_i[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        be_n    = 4'b0011 << {mem_addr_i[1], 1'b0};
        wdata_n = {2{mem_sdata_i[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = mem_sdata_i;
      end
    endcase
  end

  // Address inputs are held by upstream during the stall, so DONE can reuse them for lane selection.
  assign byte_sh = rdata_q >> {mem_addr_i[1:0], 3'b000};
  assign half_sh = rdata_q >> {mem_addr_i[1], 4'b0000};

  always_comb begin
    case (mem_op_i)
      OP_LB:   load_val = {{24{byte_sh[7]}}, byte_sh[7:0]};
      OP_LBU:  load_val = {24'd0, byte_sh[7:0]};
      OP_LH:   load_val = {{16{half_sh[15]}}, half_sh[15:0]};
      OP_LHU:  load_val = {16'd0, half_sh[15:0]};
      default: load_val = rdata_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      cnt          <= '0;
      rdata_q      <= '0;
      timeout_q    <= 1'b0;
      bus_err_q    <= 1'b0;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_be_o    <= '0;
      dbus_wdata_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt       <= '0;
          timeout_q <= 1'b0;
          bus_err_q <= 1'b0;
          if (mem_go) begin
            state        <= S_REQ;
            dbus_req_o   <= 1'b1;
            dbus_we_o    <= is_store;
            dbus_addr_o  <= {mem_addr_i[31:2], 2'b00};
            dbus_be_o    <= be_n;
            dbus_wdata_o <= wdata_n;
          end
        end
        S_REQ: begin
          cnt <= cnt + 1'b1;
          // Ack takes priority over a timeout landing in the same cycle.
          if (dbus_ack_i) begin
            rdata_q    <= dbus_rdata_i;
            dbus_req_o <= 1'b0;
            state      <= S_DONE;
          end else if (timeout_hit) begin
            dbus_req_o <= 1'b0;
            bus_err_q  <= 1'b1;
            timeout_q  <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          bus_err_q <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus_err_o = bus_err_q;

  always_comb begin
    reg_waddr_o = reg_waddr_i;
    reg_we_o    = reg_we_i;
    reg_wdata_o = reg_wdata_i;
    stallreq_o  = 1'b0;
    misalign_o  = 1'b0;
    case (state)
      S_IDLE: begin
        misalign_o = misalign;
        if (misalign) begin
          reg_we_o = 1'b0;
        end else if (mem_go) begin
          stallreq_o = 1'b1;
          reg_we_o   = 1'b0;
        end
      end
      S_REQ: begin
        stallreq_o = 1'b1;
        reg_we_o   = 1'b0;
      end
      S_DONE: begin
        if (is_load) begin
          reg_we_o    = reg_we_i & ~timeout_q;
          reg_wdata_o = load_val;
        end else begin
          reg_we_o = 1'b0;
        end
      end
      default: ;
    endcase
    if (rst_i) begin
      reg_waddr_o = '0;
      reg_we_o    = 1'b0;
      reg_wdata_o = '0;
      stallreq_o  = 1'b0;
      misalign_o  = 1'b0;
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage between the exe_mem pipeline register and the mem_wb register.
- Loads: performs byte-lane selection, then sign or zero extension.
- Stores: generates byte enables and replicates the store data across lanes.
- Drives a req/ack data bus, requests a pipeline stall while an access is outstanding, and flags misaligned accesses and bus timeouts.
- Non-memory instructions pass through to mem_wb with zero latency.

Parameters:
- TIMEOUT_CYCLES, 16: cycles spent in REQ without ack before the access is aborted; 0 disables the timeout.
- CNT_WIDTH, 5: timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- reg_waddr_i  in  `RADDR_WIDTH  destination register from exe_mem
- reg_we_i  in  1  register write enable from exe_mem
- reg_wdata_i  in  `RDATA_WIDTH  ALU result from exe_mem
- mem_op_i  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; any other value = NONE
- mem_addr_i  in  32  effective byte address
- mem_sdata_i  in  32  store data (rs2)
- reg_waddr_o  out  `RADDR_WIDTH  to mem_wb
- reg_we_o  out  1  to mem_wb
- reg_wdata_o  out  `RDATA_WIDTH  to mem_wb
- dbus_req_o  out  1  bus request, registered
- dbus_we_o  out  1  1 = write
- dbus_addr_o  out  32  word-aligned address
- dbus_be_o  out  4  byte enables
- dbus_wdata_o  out  32  lane-replicated store data
- dbus_rdata_i  in  32  read data, valid with ack
- dbus_ack_i  in  1  access complete
- stallreq_o  out  1  to pipeline control; holds the stages upstream of and including this one
- misalign_o  out  1  misaligned access this cycle
- bus_err_o  out  1  one-cycle pulse on timeout

Behaviour:
- Reset is asynchronous: FSM goes to IDLE, dbus_req_o and the dbus_* registers clear to 0, and the counter and capture register clear to 0.
- While rst_i is high, every output is 0.
- An in-flight bus access is abandoned on reset; a late ack after reset is ignored.
- Alignment rule:
  - LH, LHU, SH are misaligned if addr[0] is 1.
  - LW, SW are misaligned if addr[1:0] is not 0.
  - A misaligned op issues no bus access and forces reg_we_o = 0.
  - misalign_o = 1 combinationally in that cycle; no stall.
- IDLE:
  - NONE op: outputs = inputs combinationally; stallreq_o = 0.
  - Aligned load/store: stallreq_o = 1 combinationally; next state REQ.
  - The dbus registers load word address {addr[31:2],2'b00}, dbus_we_o, dbus_be_o, dbus_wdata_o; dbus_req_o <= 1.
- Byte enables:
  - SB: 4'b0001 << addr[1:0].
  - SH: 4'b0011 << {addr[1],1'b0}.
  - SW: 4'b1111.
  - Loads use the same masks; the bus may ignore be on reads.
- Store data:
  - SB: {4{sdata[7:0]}}.
  - SH: {2{sdata[15:0]}}.
  - SW: sdata.
- REQ:
  - stallreq_o = 1; the dbus_* signals stay stable; the counter increments each cycle.
  - On dbus_ack_i: capture dbus_rdata_i, drop dbus_req_o, go to DONE.
  - On counter reaching TIMEOUT_CYCLES - 1 with no ack: drop dbus_req_o, pulse bus_err_o for 1 cycle, go to DONE with the writeback suppressed.
  - Ack is only legal while dbus_req_o is high; ack and timeout in the same cycle resolve as ack.
- DONE (1 cycle):
  - stallreq_o = 0; reg_waddr_o = reg_waddr_i.
  - Load: reg_wdata_o = extracted and extended captured data; reg_we_o = reg_we_i, or 0 after a timeout.
  - Store: reg_we_o = 0.
  - Next state is IDLE, which evaluates the next instruction in the following cycle.
- Upstream holds its inputs stable while stallreq_o is high.
- Load extract: byte = word >> (8*addr[1:0]); half = word >> (16*addr[1]).
  - LB, LH sign-extend; LBU, LHU zero-extend; LW passes the word.
- Latency: ack sampled in cycle k produces the result and stallreq_o = 0 in cycle k+1. Minimum access time is 2 cycles (ack in the first REQ cycle).

Test Plan:
- Pass-through: mem_op_i=0, reg_waddr_i=5, reg_we_i=1, reg_wdata_i=0x1234 -> same values on the outputs the same cycle; stallreq_o=0; dbus_req_o=0.
- LB sign extension: addr=0x1003, mem rdata=0x80FF_0000, ack on the 2nd REQ cycle -> dbus_addr_o=0x1000, be=4'b1000; stallreq high 3 cycles; DONE reg_wdata_o=0xFFFF_FF80.
- LHU: addr=0x2002, rdata=0xBEEF_1234 -> reg_wdata_o=0x0000_BEEF.
- SB: addr=0x3001, sdata=0xAB -> wdata=0xABAB_ABAB, be=4'b0010, we=1; DONE reg_we_o=0.
- Misaligned LW: addr=0x4002 -> misalign_o=1, reg_we_o=0, no dbus_req_o, stallreq_o=0.
- Timeout and reset:
  - TIMEOUT_CYCLES=4, no ack -> dbus_req_o high 4 cycles, bus_err_o pulse, reg_we_o=0 in DONE.
  - Separately, rst_i asserted mid-REQ -> dbus_req_o=0 immediately, FSM in IDLE.
